// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared definitions for the SHA-256 front end. Holds the
//                padder state encoding, the padding marker word, the block
//                geometry, the 512-bit block type, and a helper function that
//                builds the terminating word of a short final input word.
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

  // First padding byte (0x80) placed at the most significant byte of a word.
  localparam logic [31:0] SHA256_MARKER = 32'h8000_0000;

  // Number of 32-bit words in one SHA-256 message block.
  localparam int BLOCK_WORDS = 16;

  // Padder state encoding (explicit 2-bit width).
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,   // accepting message words
    ST_PAD  = 2'd1,   // writing marker / zero / length words, one per cycle
    ST_EMIT = 2'd2    // presenting a complete block downstream
  } pad_state_t;

  // One message block; word 0 occupies [511:480], word 15 occupies [31:0].
  typedef logic [BLOCK_WORDS*32-1:0] block_t;

  // Build the final word of a message that carries fewer than four bytes:
  // keep the top nbytes bytes, place 0x80 right after them, zero the rest.
  function automatic logic [31:0] terminate_word(
    input logic [31:0] data,
    input logic [1:0]  nbytes
  );
    logic [4:0]  shamt;
    logic [31:0] keep_mask;
    shamt     = {nbytes, 3'b000};
    keep_mask = ~(32'hFFFF_FFFF >> shamt);
    return (data & keep_mask) | (SHA256_MARKER >> shamt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_padder
//  Description : SHA-256 message padder. Collects big-endian 32-bit message
//                words into 512-bit blocks, appends the 0x80 marker, zero
//                fill and the 64-bit big-endian bit length, and hands each
//                block to the compression core with first/last tags.
//
//  Ports
//    clk        : clock, all logic on the rising edge
//    reset      : synchronous active-high reset
//    in_valid   : message word offered
//    in_ready   : word accepted when in_valid & in_ready (high only in fill)
//    in_data    : message word, first byte in [31:24]
//    in_last    : offered word is the final word of the message
//    in_bytes   : valid bytes in the final word (0..4, MSB aligned, >4 = 4)
//    blk_valid  : complete block available
//    blk_ready  : downstream takes the block when blk_valid & blk_ready
//    blk_data   : block, word 0 in [511:480], word 15 in [31:0]
//    blk_first  : block is the first block of a message
//    blk_last   : block carries the length field (final block of a message)
//    busy       : padder holds partial state (not idle at word 0 of fill)
//
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_padder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy
);

  localparam logic [3:0] LAST_WORD   = 4'(BLOCK_WORDS - 1);
  localparam logic [3:0] LEN_HI_WORD = 4'(BLOCK_WORDS - 2);

  pad_state_t  state;
  pad_state_t  state_next;

  logic [3:0]  w_idx;
  block_t      buffer;
  logic [63:0] bit_len;
  logic        marker_pending;  // final word was full; marker still owed
  logic        marker_done;     // 0x80 marker already placed in the stream
  logic        len_written;     // length high word stored in this block
  logic        msg_ended;       // final word of the message accepted
  logic        first_blk;

  logic        accept;
  logic [2:0]  last_bytes;
  logic [31:0] fill_word;
  logic [31:0] pad_word;
  logic [63:0] len_incr;
  logic [8:0]  word_lsb;

  assign accept     = in_valid & in_ready;
  assign last_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;

  // Word index i lives at bit offset (15 - i) * 32; ~w_idx is 15 - w_idx.
  assign word_lsb   = {~w_idx, 5'b00000};

  // A short final word is terminated in place; a full one is stored as is
  // and the marker goes into the following word during padding.
  assign fill_word  = (in_last && (last_bytes != 3'd4))
                    ? terminate_word(in_data, last_bytes[1:0])
                    : in_data;

  assign len_incr   = in_last ? {58'd0, last_bytes, 3'b000} : 64'd32;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_FILL: begin
        if (accept) begin
          if (w_idx == LAST_WORD) begin
            state_next = ST_EMIT;
          end else if (in_last) begin
            state_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (w_idx == LAST_WORD) begin
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          if (len_written) begin
            state_next = ST_FILL;
          end else if (msg_ended) begin
            state_next = ST_PAD;     // marker or length spills to a new block
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / padding-word logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    pad_word  = 32'd0;

    unique case (state)
      ST_FILL: in_ready  = 1'b1;
      ST_EMIT: blk_valid = 1'b1;
      default: ;
    endcase

    // The length only goes in when the marker was placed before word 14 of
    // this block (or in an earlier block); otherwise the block is zero
    // filled and the length follows in an extra block.
    if (marker_pending) begin
      pad_word = SHA256_MARKER;
    end else if ((w_idx == LEN_HI_WORD) && marker_done) begin
      pad_word = bit_len[63:32];
    end else if ((w_idx == LAST_WORD) && len_written) begin
      pad_word = bit_len[31:0];
    end
  end

  assign busy      = (state != ST_FILL) || (w_idx != 4'd0);
  assign blk_data  = buffer;
  assign blk_first = first_blk;
  assign blk_last  = len_written;

  // --------------------------------------------------------------------------
  // Block buffer, word index, length counter and padding flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      w_idx          <= 4'd0;
      buffer         <= '0;
      bit_len        <= 64'd0;
      marker_pending <= 1'b0;
      marker_done    <= 1'b0;
      len_written    <= 1'b0;
      msg_ended      <= 1'b0;
      first_blk      <= 1'b1;
    end else begin
      unique case (state)
        ST_FILL: begin
          if (accept) begin
            buffer[word_lsb +: 32] <= fill_word;
            w_idx                  <= w_idx + 4'd1;
            bit_len                <= bit_len + len_incr;   // wraps mod 2^64
            if (in_last) begin
              msg_ended <= 1'b1;
              if (last_bytes == 3'd4) begin
                marker_pending <= 1'b1;
              end else begin
                marker_done    <= 1'b1;
              end
            end
          end
        end
        ST_PAD: begin
          buffer[word_lsb +: 32] <= pad_word;
          w_idx                  <= w_idx + 4'd1;
          if (marker_pending) begin
            marker_pending <= 1'b0;
            marker_done    <= 1'b1;
          end else if ((w_idx == LEN_HI_WORD) && marker_done) begin
            len_written <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            w_idx  <= 4'd0;
            buffer <= '0;
            if (len_written) begin
              // Message complete: start clean for the next one.
              bit_len        <= 64'd0;
              marker_pending <= 1'b0;
              marker_done    <= 1'b0;
              len_written    <= 1'b0;
              msg_ended      <= 1'b0;
              first_blk      <= 1'b1;
            end else begin
              first_blk      <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_padder
//  Description : Self-checking bench for sha256_padder. Messages are queued
//                as input words; a byte-level model applies the SHA-256
//                padding rule (append 0x80, zero fill to 56 mod 64, append
//                64-bit bit length) and splits the result into expected
//                blocks with first/last tags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_padder;

  localparam int LIMIT = 20000;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data   = 32'd0;
  logic         in_last   = 1'b0;
  logic [2:0]   in_bytes  = 3'd0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Pending input words and expected output blocks.
  logic [31:0]  q_data[$];
  logic         q_last[$];
  logic [2:0]   q_bytes[$];
  logic [511:0] e_data[$];
  logic         e_first[$];
  logic         e_last[$];
  logic [7:0]   msg[$];

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Standard SHA-256 padding of the collected message bytes.
  task automatic close_message();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    bits = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      e_data.push_back(blk);
      e_first.push_back(b == 0);
      e_last.push_back(b == nblk - 1);
    end
    msg.delete();
  endtask

  task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] b);
    int n;
    q_data.push_back(d);
    q_last.push_back(last);
    q_bytes.push_back(b);
    n = last ? ((b > 3'd4) ? 4 : int'(b)) : 4;
    for (int k = 0; k < n; k++) msg.push_back(d[31-8*k -: 8]);
    if (last) close_message();
  endtask

  // Drive all queued words and collect all expected blocks. Each block is
  // held for a random number of stall cycles in [smin,smax]; input words are
  // withheld with probability gap percent (but always offered during emit).
  task automatic run_stream(input int smin, input int smax, input int gap);
    int           ptr;
    int           cyc;
    int           stall;
    logic [511:0] snap;
    ptr   = 0;
    cyc   = 0;
    stall = -1;
    snap  = '0;
    while (((ptr < q_data.size()) || (e_data.size() != 0)) && (cyc < LIMIT)) begin
      @(negedge clk);
      cyc++;
      blk_ready = 1'b0;
      if (blk_valid) begin
        if (e_data.size() == 0) begin
          check("spurious_block", blk_valid, 1'b0);
          break;
        end
        check("in_ready_in_emit", in_ready, 1'b0);
        if (stall < 0) begin
          stall = $urandom_range(smax, smin);
          snap  = blk_data;
        end else begin
          check("blk_data_stable", blk_data, snap);
        end
        if (stall == 0) begin
          blk_ready = 1'b1;
          check("blk_data", blk_data, e_data[0]);
          check("blk_first", blk_first, e_first[0]);
          check("blk_last", blk_last, e_last[0]);
          void'(e_data.pop_front());
          void'(e_first.pop_front());
          void'(e_last.pop_front());
          stall = -1;
        end else begin
          stall--;
        end
      end
      if (ptr < q_data.size()) begin
        in_valid = blk_valid || (gap == 0) || ($urandom_range(99, 0) >= gap);
        in_data  = q_data[ptr];
        in_last  = q_last[ptr];
        in_bytes = q_bytes[ptr];
        if (in_valid && in_ready) ptr++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
      end
    end
    check("stream_done", cyc < LIMIT, 1'b1);
    @(negedge clk);
    blk_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    q_data.delete();
    q_last.delete();
    q_bytes.delete();
    e_data.delete();
    e_first.delete();
    e_last.delete();
    msg.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
  endtask

  initial begin
    int nw;

    apply_reset();

    // "abc"
    push_word(32'h6162_6300, 1'b1, 3'd3);
    run_stream(0, 0, 0);

    // Empty message
    push_word($urandom, 1'b1, 3'd0);
    run_stream(0, 2, 0);

    // 14 full words, final one full: marker in word 14, length in block 2
    for (int i = 0; i < 13; i++) push_word($urandom, 1'b0, 3'($urandom_range(7, 0)));
    push_word($urandom, 1'b1, 3'd4);
    run_stream(0, 2, 20);

    // 16 full words, then "abc" back to back (first flag must return)
    for (int i = 0; i < 15; i++) push_word($urandom, 1'b0, 3'd0);
    push_word($urandom, 1'b1, 3'd4);
    push_word(32'h6162_6300, 1'b1, 3'd3);
    run_stream(1, 3, 0);

    // in_bytes above 4 treated as 4; final short word landing at word 14/15
    push_word($urandom, 1'b1, 3'd7);
    for (int i = 0; i < 14; i++) push_word($urandom, 1'b0, 3'd5);
    push_word($urandom, 1'b1, 3'd2);
    for (int i = 0; i < 15; i++) push_word($urandom, 1'b0, 3'd1);
    push_word($urandom, 1'b1, 3'd1);
    run_stream(0, 1, 10);

    // Blocks held for 5 cycles while the next message is offered
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 3'd0);
    push_word($urandom, 1'b1, 3'd2);
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b0, 3'd0);
    push_word($urandom, 1'b1, 3'd0);
    run_stream(5, 5, 0);

    // Reset while padding, then "abc"
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = (i == 2);
      in_bytes = 3'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("pad_busy", busy, 1'b1);
    check("pad_in_ready", in_ready, 1'b0);
    apply_reset();
    push_word(32'h6162_6300, 1'b1, 3'd3);
    run_stream(0, 0, 0);

    // Reset while a block is waiting, then "abc"
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'b0;
      in_bytes = 3'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("emit_valid", blk_valid, 1'b1);
    apply_reset();
    push_word(32'h6162_6300, 1'b1, 3'd3);
    run_stream(0, 1, 0);

    // Random messages
    for (int m = 0; m < 20; m++) begin
      nw = $urandom_range(40, 0);
      for (int i = 0; i < nw; i++) push_word($urandom, 1'b0, 3'($urandom_range(7, 0)));
      push_word($urandom, 1'b1, 3'($urandom_range(7, 0)));
    end
    run_stream(0, 3, 25);

    repeat (5) @(negedge clk);
    check("idle_blk_valid", blk_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
